regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
// - Owns the single write port (W, W_Adr, we) of the 8x16 register file.
// - After reset, sweeps every register to INIT_VAL, then round-robins write-back
//   requests from NREQ sources (e.g. ALU, load unit) onto that port.
// - Sits between the execute/write-back stages and the register file.
// PARAMETERS
// - NREQ      2      number of write requesters (2..8)
// - DW        16     data width
// - AW        3      register address width
// - NREG      8      registers swept at init (NREG <= 2**AW)
// - INIT_VAL  16'h0  value written to every register during init sweep
// PORTS
// - clk         in   1         rising-edge clock
// - reset       in   1         asynchronous reset, active-low (0 = in reset)
// - init_start  in   1         pulse: re-run init sweep (honoured in RUN only)
// - req_valid   in   NREQ      per-requester write request
// - req_adr     in   NREQ*AW   request i address in bits [i*AW +: AW]
// - req_data    in   NREQ*DW   request i data in bits [i*DW +: DW]
// - req_ready   out  NREQ      one-hot grant; transfer = valid & ready
// - we          out  1         register-file write enable (registered)
// - W_Adr       out  AW        register-file write address (registered)
// - W           out  DW        register-file write data (registered)
// - init_done   out  1         1 while in RUN
// BEHAVIOUR
// - Reset (reset==0, async): state=INIT, sweep cnt=0, rr pointer=0, we=0,
//   W_Adr=0, W=0, init_done=0, req_ready=0. Reset mid-sweep restarts at reg 0.
// - FSM states: INIT, RUN.
//   INIT: each cycle registers we=1, W_Adr=cnt, W=INIT_VAL; cnt++.
//     At cnt==NREG-1: next state RUN, cnt=0. Sweep = exactly NREG write cycles.
//     req_ready=0 throughout INIT. init_start ignored in INIT.
//   RUN: init_done=1. init_start==1 -> next state INIT, no grant that cycle,
//     req_ready=0, we=0 next cycle.
// - Arbitration (RUN, no init_start): combinational. Grant = first i with
//   req_valid[i]==1 searching ptr, ptr+1, ... mod NREQ. req_ready=grant.
//   req_ready depends combinationally on req_valid; requesters must not
//   derive valid from ready, and must hold valid/adr/data until transfer.
// - Pointer: after transfer from i, ptr=(i+1) mod NREQ; unchanged when idle.
// - Latency: transfer at edge k -> we=1, W_Adr/W = granted adr/data in cycle
//   k..k+1; register file captures at edge k+1. One write per cycle max.
// - Idle cycle (no valid): we=0 next cycle; W_Adr/W hold last value.
// - Two requesters same address same cycle: only granted one written; other
//   waits; writes land in grant order (no merging, no ordering by address).
// - No back-pressure from register file: port always accepts.
// STRUCTURE
// - Shared package (regfile_pkg): FSM state encoding (ST_INIT, ST_RUN), AW/DW/NREG
//   defaults, INIT_VAL constant.
// - Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs one-hot gnt[N], gnt_idx.
//   Top holds FSM, sweep counter, pointer register, output registers.
// TESTING
// - Release reset -> 8 cycles we=1, W_Adr=0..7, W=0; init_done=1 from cycle 9;
//   req_ready=0 for those 8 cycles.
// - RUN, req0 valid adr=3 data=16'hBEEF -> req_ready=2'b01 same cycle; next
//   cycle we=1, W_Adr=3, W=16'hBEEF; following cycle we=0 if no requests.
// - Both valid continuously (adr 1/2) -> grants 0,1,0,1...; W_Adr 1,2,1,2 on
//   consecutive cycles, no idle gaps.
// - init_start with req1 valid -> req1 stalls; 8 sweep writes of 0; req1 served
//   in first RUN cycle, its write lands after the sweep (never overwritten).
// - reset=0 asserted at sweep cnt=4 -> we/W_Adr/W/init_done=0 immediately;
//   after release sweep restarts at W_Adr=0.
// - Same address 5 from req0 (16'h1111) and req1 (16'h2222), ptr=1 -> req1
//   first, then req0; register 5 ends 16'h1111.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int unsigned DEF_NREQ = 2;
    localparam int unsigned DEF_DW   = 16;
    localparam int unsigned DEF_AW   = 3;
    localparam int unsigned DEF_NREG = 8;

    localparam logic [DEF_DW-1:0] DEF_INIT_VAL = 16'h0000;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester/register-file bundle around the single write port.
interface regfile_wr_arbiter_if
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned AW   = DEF_AW
) ();

    logic                 init_start;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_adr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 we;
    logic [AW-1:0]        W_Adr;
    logic [DW-1:0]        W;
    logic                 init_done;

    modport master (
        output init_start, req_valid, req_adr, req_data,
        input  req_ready, we, W_Adr, W, init_done
    );

    modport slave (
        input  init_start, req_valid, req_adr, req_data,
        output req_ready, we, W_Adr, W, init_done
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module regfile_wr_arbiter_rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = IW'((int'(ptr) + k) % int'(N));
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: init sweep after reset, then round-robin write-back.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned   NREQ     = DEF_NREQ,
    parameter int unsigned   DW       = DEF_DW,
    parameter int unsigned   AW       = DEF_AW,
    parameter int unsigned   NREG     = DEF_NREG,
    parameter logic [DW-1:0] INIT_VAL = DW'(DEF_INIT_VAL)
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);

    localparam int unsigned   PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

    state_e          state;
    logic [AW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic            we_q;
    logic [AW-1:0]   wadr_q;
    logic [DW-1:0]   wdata_q;
    logic            init_done_q;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            grant_en;
    logic            xfer;
    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_data;

    regfile_wr_arbiter_rr_arbiter #(
        .N  (NREQ),
        .IW (PW)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A pending init_start suppresses the grant so nothing is lost across the sweep.
    assign grant_en      = (state == ST_RUN) && !bus.init_start;
    assign bus.req_ready = grant_en ? gnt : '0;
    assign xfer          = grant_en && (|bus.req_valid);

    always_comb begin
        sel_adr  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_adr  = bus.req_adr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            cnt         <= '0;
            ptr         <= '0;
            we_q        <= 1'b0;
            wadr_q      <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    we_q    <= 1'b1;
                    wadr_q  <= cnt;
                    wdata_q <= INIT_VAL;
                    if (cnt == LAST_REG) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.init_start) begin
                        state       <= ST_INIT;
                        cnt         <= '0;
                        init_done_q <= 1'b0;
                        we_q        <= 1'b0;
                    end else if (xfer) begin
                        we_q    <= 1'b1;
                        wadr_q  <= sel_adr;
                        wdata_q <= sel_data;
                        ptr     <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.we        = we_q;
    assign bus.W_Adr     = wadr_q;
    assign bus.W         = wdata_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: vector table plus init/reset corner sequences.
module tb_regfile_wr_arbiter;
    import regfile_wr_arbiter_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_wr_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .AW       (AW),
        .NREG     (NREG),
        .INIT_VAL (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file as seen downstream: captures on the edge after we/W_Adr/W are presented.
    logic [DW-1:0] rf [NREG];
    always @(posedge clk) if (bus.we) rf[bus.W_Adr] <= bus.W;

    typedef struct {
        logic [1:0]  valid;
        logic [2:0]  adr0;
        logic [2:0]  adr1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  ready;
        logic        we;
        logic [2:0]  wadr;
        logic [15:0] w;
    } vec_t;

    vec_t vecs [14];
    logic [15:0] rf_exp [NREG];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] valid, input logic [2:0] a0, input logic [2:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        bus.req_valid = valid;
        bus.req_adr   = {a1, a0};
        bus.req_data  = {d1, d0};
    endtask

    initial begin
        //            valid  a0    a1    d0        d1        ready  we    wadr  w
        vecs[0]  = '{2'b01, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 2'b01, 1'b1, 3'd3, 16'hBEEF};
        vecs[1]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b00, 1'b0, 3'd3, 16'hBEEF};
        vecs[2]  = '{2'b11, 3'd1, 3'd2, 16'hA001, 16'hB002, 2'b10, 1'b1, 3'd2, 16'hB002};
        vecs[3]  = '{2'b11, 3'd1, 3'd2, 16'hA001, 16'hB002, 2'b01, 1'b1, 3'd1, 16'hA001};
        vecs[4]  = '{2'b11, 3'd1, 3'd2, 16'hA001, 16'hB002, 2'b10, 1'b1, 3'd2, 16'hB002};
        vecs[5]  = '{2'b11, 3'd1, 3'd2, 16'hA001, 16'hB002, 2'b01, 1'b1, 3'd1, 16'hA001};
        vecs[6]  = '{2'b01, 3'd6, 3'd0, 16'h0066, 16'h0000, 2'b01, 1'b1, 3'd6, 16'h0066};
        vecs[7]  = '{2'b01, 3'd4, 3'd0, 16'h0044, 16'h0000, 2'b01, 1'b1, 3'd4, 16'h0044};
        vecs[8]  = '{2'b10, 3'd0, 3'd0, 16'h0000, 16'h1234, 2'b10, 1'b1, 3'd0, 16'h1234};
        vecs[9]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b00, 1'b0, 3'd0, 16'h1234};
        vecs[10] = '{2'b01, 3'd7, 3'd0, 16'h0777, 16'h0000, 2'b01, 1'b1, 3'd7, 16'h0777};
        vecs[11] = '{2'b11, 3'd5, 3'd5, 16'h1111, 16'h2222, 2'b10, 1'b1, 3'd5, 16'h2222};
        vecs[12] = '{2'b01, 3'd5, 3'd0, 16'h1111, 16'h0000, 2'b01, 1'b1, 3'd5, 16'h1111};
        vecs[13] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b00, 1'b0, 3'd5, 16'h1111};

        rf_exp = '{16'h1234, 16'hA001, 16'hB002, 16'hBEEF,
                   16'h0044, 16'h1111, 16'h0066, 16'h0777};

        bus.init_start = 1'b0;
        drive(2'b11, 3'd0, 3'd0, 16'h0, 16'h0);

        // Reset state
        #2;
        chk("rst_we", 32'(bus.we), 32'h0);
        chk("rst_wadr", 32'(bus.W_Adr), 32'h0);
        chk("rst_w", 32'(bus.W), 32'h0);
        chk("rst_init_done", 32'(bus.init_done), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("init_ready_pre", 32'(bus.req_ready), 32'h0);

        // Init sweep: NREG writes of INIT_VAL, requests held off throughout
        for (int i = 0; i < int'(NREG); i++) begin
            tick();
            chk("sweep_we", 32'(bus.we), 32'h1);
            chk("sweep_wadr", 32'(bus.W_Adr), 32'(i));
            chk("sweep_w", 32'(bus.W), 32'h0);
            chk("sweep_init_done", 32'(bus.init_done), (i == int'(NREG) - 1) ? 32'h1 : 32'h0);
            if (i < int'(NREG) - 1) chk("sweep_ready", 32'(bus.req_ready), 32'h0);
        end
        drive(2'b00, 3'd0, 3'd0, 16'h0, 16'h0);

        // Table-driven arbitration vectors
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].valid, vecs[v].adr0, vecs[v].adr1, vecs[v].d0, vecs[v].d1);
            #1;
            chk($sformatf("v%0d_ready", v), 32'(bus.req_ready), 32'(vecs[v].ready));
            tick();
            chk($sformatf("v%0d_we", v), 32'(bus.we), 32'(vecs[v].we));
            chk($sformatf("v%0d_wadr", v), 32'(bus.W_Adr), 32'(vecs[v].wadr));
            chk($sformatf("v%0d_w", v), 32'(bus.W), 32'(vecs[v].w));
        end
        for (int r = 0; r < int'(NREG); r++)
            chk($sformatf("rf%0d", r), 32'(rf[r]), 32'(rf_exp[r]));

        // init_start while req1 waits: req1 stalls through the sweep, lands after it
        bus.init_start = 1'b1;
        drive(2'b10, 3'd0, 3'd2, 16'h0, 16'hCAFE);
        #1 chk("istart_ready", 32'(bus.req_ready), 32'h0);
        tick();
        bus.init_start = 1'b0;
        chk("istart_we", 32'(bus.we), 32'h0);
        chk("istart_init_done", 32'(bus.init_done), 32'h0);
        for (int i = 0; i < int'(NREG); i++) begin
            chk("resweep_ready", 32'(bus.req_ready), 32'h0);
            tick();
            chk("resweep_we", 32'(bus.we), 32'h1);
            chk("resweep_wadr", 32'(bus.W_Adr), 32'(i));
            chk("resweep_w", 32'(bus.W), 32'h0);
        end
        chk("resweep_done", 32'(bus.init_done), 32'h1);
        chk("stalled_ready", 32'(bus.req_ready), 32'h2);
        tick();
        chk("stalled_we", 32'(bus.we), 32'h1);
        chk("stalled_wadr", 32'(bus.W_Adr), 32'h2);
        chk("stalled_w", 32'(bus.W), 32'hCAFE);
        drive(2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        tick();
        chk("post_idle_we", 32'(bus.we), 32'h0);
        chk("rf2_after_sweep", 32'(rf[2]), 32'hCAFE);
        chk("rf5_swept", 32'(rf[5]), 32'h0);
        chk("rf3_swept", 32'(rf[3]), 32'h0);

        // Reset in the middle of a sweep restarts it from register 0
        bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
        repeat (4) tick();
        chk("mid_we", 32'(bus.we), 32'h1);
        chk("mid_wadr", 32'(bus.W_Adr), 32'h3);
        reset = 1'b0;
        #1;
        chk("async_we", 32'(bus.we), 32'h0);
        chk("async_wadr", 32'(bus.W_Adr), 32'h0);
        chk("async_w", 32'(bus.W), 32'h0);
        chk("async_init_done", 32'(bus.init_done), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("restart_we", 32'(bus.we), 32'h1);
        chk("restart_wadr0", 32'(bus.W_Adr), 32'h0);
        tick();
        chk("restart_wadr1", 32'(bus.W_Adr), 32'h1);
        repeat (6) tick();
        chk("restart_wadr7", 32'(bus.W_Adr), 32'h7);
        chk("restart_done", 32'(bus.init_done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
